// File: rtl/des_pkg.sv
// DES key-schedule shared types, permutation tables and rotation helpers.
// Table entries use DES 1-based bit numbering; bit 1 is the MSB.
package des_pkg;

  typedef logic [47:0] round_key_t;
  typedef logic [27:0] half_key_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } ks_state_t;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHEDULE [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd1
  };

  // Out-of-range rounds only occur on paths that are never taken.
  function automatic logic [1:0] shift_of(logic [4:0] r);
    if (r >= 5'd1 && r <= 5'd16) return SHIFT_SCHEDULE[r];
    return 2'd1;
  endfunction

  function automatic half_key_t rotl(half_key_t h, logic [1:0] n);
    return (n == 2'd2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic half_key_t rotr(half_key_t h, logic [1:0] n);
    return (n == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2_permute.sv
// DES PC-2 compression: 56-bit C||D (bit 55 = C bit 1) to 48-bit key.
// Ports: cd (in, 56) rotated halves; key (out, 48) bit 47 = PC-2 bit 1.
module des_pc2_permute
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output round_key_t  key
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign key[47-i] = cd[56-PC2_TBL[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator, one key per valid/ready handshake.
// Ports: clk, rst_n, key_load, key_in, decrypt, round_ready in; round_key, round_idx, key_valid, busy, done out.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        round_ready,
  output round_key_t  round_key,
  output logic [3:0]  round_idx,
  output logic        key_valid,
  output logic        busy,
  output logic        done
);

  logic [1:0] rst_sync;
  logic       rst_i_n;

  // Reset asserts asynchronously, releases two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i_n = rst_sync[1];

  half_key_t  c0, d0;
  half_key_t  c, d;
  half_key_t  c_nx, d_nx;
  half_key_t  c_init, d_init;
  round_key_t k_nx;
  ks_state_t  state;
  logic       dec;
  logic       accept;
  logic       last;
  logic       unused_parity;

  for (genvar i = 0; i < 28; i++) begin : g_pc1
    assign c0[27-i] = key_in[64-PC1_TBL[i]];
    assign d0[27-i] = key_in[64-PC1_TBL[i+28]];
  end

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign accept = key_valid & round_ready;
  assign last   = dec ? (round_idx == 4'(16 - NUM_ROUNDS))
                      : (round_idx == 4'(NUM_ROUNDS - 1));

  // Encrypt walks C/D forward; decrypt starts at C16=C0 and walks back.
  always_comb begin
    c_nx = c;
    d_nx = d;
    if (state == ST_IDLE) begin
      c_nx = decrypt ? c0 : rotl(c0, 2'd1);
      d_nx = decrypt ? d0 : rotl(d0, 2'd1);
    end else if (dec) begin
      c_nx = rotr(c, shift_of({1'b0, round_idx} + 5'd1));
      d_nx = rotr(d, shift_of({1'b0, round_idx} + 5'd1));
    end else begin
      c_nx = rotl(c, shift_of({1'b0, round_idx} + 5'd2));
      d_nx = rotl(d, shift_of({1'b0, round_idx} + 5'd2));
    end
  end

  des_pc2_permute u_pc2 (
    .cd  ({c_nx, d_nx}),
    .key (k_nx)
  );

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state     <= ST_IDLE;
      c         <= '0;
      d         <= '0;
      c_init    <= '0;
      d_init    <= '0;
      dec       <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_load) begin
            state     <= ST_GEN;
            dec       <= decrypt;
            c         <= c_nx;
            d         <= d_nx;
            c_init    <= c0;
            d_init    <= d0;
            round_key <= k_nx;
            round_idx <= decrypt ? 4'd15 : 4'd0;
            key_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_GEN: begin
          if (accept) begin
            if (last) begin
              state     <= ST_IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              c         <= c_nx;
              d         <= d_nx;
              round_key <= k_nx;
              round_idx <= dec ? round_idx - 4'd1
                               : round_idx + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Total rotation over 16 rounds is 28, so C16/D16 wrap back to C0/D0.
  always_ff @(posedge clk) begin
    if (rst_i_n && state == ST_GEN && !dec && round_idx == 4'd15)
      assert (c == c_init && d == d_init);
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized self-checking bench for des_key_schedule.
// Reference keys come from cumulative-rotation DES arithmetic.
module tb_des_key_schedule;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR = 64'h0101010101010101;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic [63:0] key_in;
  logic        decrypt;
  logic        round_ready;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        key_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [47:0] exp_k [1:16];
  logic [47:0] cap [16];
  logic [47:0] enc_cap [16];

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_load    (key_load),
    .key_in      (key_in),
    .decrypt     (decrypt),
    .round_ready (round_ready),
    .round_key   (round_key),
    .round_idx   (round_idx),
    .key_valid   (key_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // K_r = PC2(C0 <<< s, D0 <<< s), s = sum of the first r shifts.
  function automatic logic [47:0] ref_key(input logic [63:0] k,
                                          input int r);
    bit c0 [28];
    bit d0 [28];
    bit cd [56];
    int s;
    logic [47:0] kv;
    s = 0;
    for (int j = 0; j < r; j++) s += T_SH[j];
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64 - T_PC1[i]];
      d0[i] = k[64 - T_PC1[i+28]];
    end
    for (int i = 0; i < 28; i++) begin
      cd[i]    = c0[(i + s) % 28];
      cd[i+28] = d0[(i + s) % 28];
    end
    kv = '0;
    for (int j = 0; j < 48; j++) kv = {kv[46:0], cd[T_PC2[j] - 1]};
    return kv;
  endfunction

  task automatic do_sched(input logic [63:0] k, input logic dec,
                          input int stall, input int ign_at,
                          input int rst_at);
    int n;
    int cyc;
    int r;
    logic rdy;
    logic [47:0] pk;
    logic [3:0] pi;
    for (int i = 1; i <= 16; i++) exp_k[i] = ref_key(k, i);
    key_in = k;
    decrypt = dec;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = ~dec;
    chk("busy_on", busy, 1);
    n = 0;
    cyc = 0;
    pk = '0;
    pi = '0;
    while (n < 16 && cyc < 400) begin
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_kv", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_key", round_key, 0);
        chk("rst_idx", round_idx, 0);
        repeat (2) @(posedge clk);
        #1 chk("rst_nodone", done, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_after_done", done, 0);
        chk("rst_after_kv", key_valid, 0);
        return;
      end
      chk("kv", key_valid, 1);
      rdy = ($urandom_range(0, 99) >= stall);
      round_ready = rdy;
      if (n == ign_at) begin
        key_load = 1'b1;
        key_in = ~k;
      end
      pk = round_key;
      pi = round_idx;
      @(posedge clk); #1;
      key_load = 1'b0;
      cyc++;
      if (rdy) begin
        r = dec ? 16 - n : n + 1;
        chk("key", pk, exp_k[r]);
        chk("idx", pi, r - 1);
        cap[n] = pk;
        n++;
      end else begin
        chk("hold_key", round_key, pk);
        chk("hold_idx", round_idx, pi);
      end
      if (n == ign_at + 1 && rdy) chk("ign_busy", busy, 1);
    end
    round_ready = 1'b0;
    if (n < 16) chk("timeout", n, 16);
    chk("done", done, 1);
    chk("kv_off", key_valid, 0);
    chk("busy_off", busy, 0);
    chk("last_key_hold", round_key, pk);
    chk("last_idx_hold", round_idx, pi);
    if (stall == 0) chk("latency", cyc, 16);
  endtask

  initial begin
    rst_n = 1'b0;
    key_load = 1'b0;
    key_in = '0;
    decrypt = 1'b0;
    round_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_kv", key_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_key", round_key, 0);
    chk("reset_idx", round_idx, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    do_sched(KEY, 1'b0, 0, -1, -1);
    chk("vec_k1", cap[0], 48'h1B02EFFC7072);
    chk("vec_k2", cap[1], 48'h79AED9DBC9E5);
    chk("vec_k16", cap[15], 48'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];

    // Load in the done cycle: back-to-back decrypt.
    do_sched(KEY, 1'b1, 0, -1, -1);
    chk("dec_first", cap[0], 48'hCB3D8B0E17F5);
    chk("dec_last", cap[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk("dec_rev", cap[i], enc_cap[15 - i]);

    repeat (3) @(posedge clk);
    #1 chk("idle_kv", key_valid, 0);

    do_sched(KEY, 1'b0, 30, -1, -1);
    for (int i = 0; i < 16; i++) chk("stall_eq", cap[i], enc_cap[i]);

    do_sched(KEY ^ PAR, 1'b0, 0, -1, -1);
    for (int i = 0; i < 16; i++) chk("parity_eq", cap[i], enc_cap[i]);

    do_sched(KEY, 1'b0, 0, 4, -1);
    for (int i = 0; i < 16; i++) chk("ign_eq", cap[i], enc_cap[i]);

    do_sched(KEY, 1'b0, 0, -1, 7);

    repeat (8) begin
      do_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 50), -1, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES round-key generator; sits directly upstream of the f-function XOR stage and drives its 48-bit round-key operand.
- Accepts a 64-bit key and emits the 16 round keys one per accepted handshake: K1..K16 for encrypt, K16..K1 for decrypt.
- Applies PC-1, performs per-round C/D rotations, applies PC-2.
- Output is registered so the consumer sees a stable key per round.

Parameters:
- NUM_ROUNDS, 16, rounds generated per key; fixed by DES, parameterised only for reduced-round debug builds (legal range 1..16).

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_load  in  1  request to start a schedule; sampled only in IDLE
- key_in  in  64  DES key; bit 63 = DES bit 1; parity bits 56,48,..,0 ignored
- decrypt  in  1  sampled with key_load; 1 = reverse order K16..K1
- round_ready  in  1  consumer accepts the current key this cycle
- round_key  out  48  current round key; bit 47 = PC-2 output bit 1
- round_idx  out  4  DES round number of round_key, 1..16 encoded 0..15
- key_valid  out  1  round_key/round_idx valid
- busy  out  1  high from the accepted load until the final key is accepted
- done  out  1  one-cycle pulse after the final key is accepted

Behaviour:
- Reset, async assert and sync deassert internally: state=IDLE, C=D=0, round_key=0, round_idx=0, key_valid=0, busy=0, done=0.
- States:
  - IDLE: a load is accepted when key_load=1.
  - GEN: a key is presented.
  - Any state not listed returns to IDLE.
- Load, IDLE & key_load at edge T:
  - Encrypt: C0/D0 = PC-1 halves. C,D rotate left 1 (shift[1]). round_key=PC2(C1,D1), round_idx=0.
  - Decrypt: C,D = C0/D0 unrotated. round_key=PC2(C0,D0)=K16, round_idx=15.
  - key_valid=1 and busy=1 from T+1. Latency is 1 cycle.
- Left-shift schedule for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Handshake: while key_valid=1 and round_ready=0, round_key, round_idx and key_valid hold unchanged. No key may be skipped or repeated.
- Advance (key_valid & round_ready, not the last round), one key per cycle at full throughput:
  - Encrypt: round r→r+1 rotates C and D left by shift[r+1].
  - Decrypt: K_r→K_{r-1} rotates C and D right by shift[r].
  - Both: register PC2 of the new C/D.
- Last round is encrypt idx=NUM_ROUNDS-1 or decrypt idx=16-NUM_ROUNDS. When accepted:
  - key_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE.
  - round_key and round_idx hold their last values.
- key_load while busy: ignored. decrypt is sampled only at load.
- key_load in the same cycle done=1: accepted, because state is already IDLE. Back-to-back schedules have one bubble cycle.
- After 16 encrypt rounds, C/D total rotation is 28, so C=C0 and D=D0. This is an assertion check.
- Reset mid-schedule: outputs return immediately to reset values and no done pulse is produced.

Decomposition:
- Shared package des_pkg holds:
  - PC1 and PC2 index tables
  - SHIFT_SCHEDULE[1:16]
  - a 2-state enum type for the FSM
  - the round_key_t (48-bit) and half_key_t (28-bit) typedefs
- The f-function stages reuse round_key_t.
- One combinational sub-module des_pc2_permute (56→48) is natural; PC-1 stays inline.

Test Plan:
- Key 0x133457799BBCDFF1, encrypt, round_ready=1: K1=0x1B02EFFC7072 at load+1, K2=0x79AED9DBC9E5 at load+2, K16=0xCB3D8B0E17F5 at load+16, done pulse at load+17.
- Same key, decrypt: first key 0xCB3D8B0E17F5 with idx=15, last 0x1B02EFFC7072 with idx=0. The sequence must equal the exact reverse of the encrypt capture.
- Random round_ready stalls (30% duty): round_key stable while stalled; exactly 16 distinct accepted keys, identical to the unstalled run.
- Parity bits of 0x133457799BBCDFF1 flipped (XOR 0x0101010101010101): identical key sequence.
- key_load pulsed at round 5 is ignored; key_load coincident with done starts a new schedule with K1 at the next cycle; rst_n low at round 8 gives key_valid=0 and busy=0 immediately with no done.
